// File: rtl/thor2021_vmem_seq.sv
// Vector/scalar memory element sequencer: walks the enabled elements, steps the address
// generator, issues one request per element and counts completions. Optional checking: VMEM_SEQ_ERRCHK_EN.
module thor2021_vmem_seq #(
    parameter int MAXVL  = 64,
    parameter int STEPW  = 6,
    parameter int MAXOUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             vec_i,
    input  logic             store_i,
    input  logic [STEPW:0]   vl_i,
    input  logic [MAXVL-1:0] mask_i,
    output logic [STEPW-1:0] step_o,
    output logic             mreq_o,
    input  logic             mreq_rdy_i,
    output logic             mreq_we_o,
    output logic [STEPW-1:0] mreq_elem_o,
    input  logic             mack_i,
    output logic             idle_o,
    output logic             done_o,
    output logic             err_o
);

    localparam int OUTW = $clog2(MAXOUT + 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_EAWAIT = 3'd2;
    localparam logic [2:0] ST_ISSUE  = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [STEPW:0]  VL_MAX  = (STEPW + 1)'(MAXVL);
    localparam logic [OUTW-1:0] OUT_MAX = OUTW'(MAXOUT);

    logic [2:0]       state_q, state_d;
    logic             store_q, store_d;
    logic [STEPW:0]   vl_q, vl_d;
    logic [MAXVL-1:0] mask_q, mask_d;
    logic [STEPW:0]   cursor_q, cursor_d;
    logic [STEPW-1:0] step_q, step_d;
    logic             mreq_q, mreq_d;
    logic [STEPW-1:0] elem_q, elem_d;
    logic [OUTW-1:0]  out_q, out_d;

    logic             found;
    logic [STEPW-1:0] found_idx;
    logic             hs;

    assign hs = mreq_q & mreq_rdy_i;

    // Lowest enabled element in [cursor, vl); iterating downward lets the lowest match win.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        for (int i = MAXVL - 1; i >= 0; i--) begin
            if (mask_q[i] && ((STEPW + 1)'(i) >= cursor_q) && ((STEPW + 1)'(i) < vl_q)) begin
                found     = 1'b1;
                found_idx = STEPW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        vl_d     = vl_q;
        mask_d   = mask_q;
        cursor_d = cursor_q;
        step_d   = step_q;
        mreq_d   = mreq_q;
        elem_d   = elem_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    store_d  = store_i;
                    cursor_d = '0;
                    state_d  = ST_SCAN;
                    if (vec_i) begin
                        vl_d   = (vl_i > VL_MAX) ? VL_MAX : vl_i;
                        mask_d = mask_i;
                    end else begin
                        vl_d   = (STEPW + 1)'(1);
                        mask_d = MAXVL'(1);
                    end
                end
            end
            ST_SCAN: begin
                if (!found) begin
                    state_d = ST_DRAIN;
                end else if (out_q < OUT_MAX) begin
                    step_d  = found_idx;
                    state_d = ST_EAWAIT;
                end
            end
            ST_EAWAIT: begin
                mreq_d  = 1'b1;
                elem_d  = step_q;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (hs) begin
                    mreq_d   = 1'b0;
                    cursor_d = {1'b0, step_q} + (STEPW + 1)'(1);
                    state_d  = ST_SCAN;
                end
            end
            ST_DRAIN: begin
                if (out_q == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                mreq_d  = 1'b0;
            end
        endcase
    end

    // A handshake and an ack in the same cycle cancel; a stray ack never underflows.
    always_comb begin
        out_d = out_q;
        if (hs && !mack_i) begin
            out_d = out_q + OUTW'(1);
        end else if (!hs && mack_i && (out_q != '0)) begin
            out_d = out_q - OUTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            vl_q     <= '0;
            mask_q   <= '0;
            cursor_q <= '0;
            step_q   <= '0;
            mreq_q   <= 1'b0;
            elem_q   <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            vl_q     <= vl_d;
            mask_q   <= mask_d;
            cursor_q <= cursor_d;
            step_q   <= step_d;
            mreq_q   <= mreq_d;
            elem_q   <= elem_d;
            out_q    <= out_d;
        end
    end

`ifdef VMEM_SEQ_ERRCHK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (mack_i && (out_q == '0))
              | (start_i && (state_q != ST_IDLE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign step_o      = step_q;
    assign mreq_o      = mreq_q;
    assign mreq_we_o   = store_q;
    assign mreq_elem_o = elem_q;
    assign idle_o      = (state_q == ST_IDLE);
    assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_thor2021_vmem_seq.sv
// Self-checking bench for thor2021_vmem_seq: directed scenarios plus randomized ops checked
// against an element-list model (expected request order, outstanding count, done timing).
module tb_thor2021_vmem_seq;

    localparam int MAXVL  = 64;
    localparam int STEPW  = 6;
    localparam int MAXOUT = 4;
`ifdef VMEM_SEQ_ERRCHK_EN
    localparam logic ERRCHK = 1'b1;
`else
    localparam logic ERRCHK = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic             vec_i;
    logic             store_i;
    logic [STEPW:0]   vl_i;
    logic [MAXVL-1:0] mask_i;
    logic [STEPW-1:0] step_o;
    logic             mreq_o;
    logic             mreq_rdy_i;
    logic             mreq_we_o;
    logic [STEPW-1:0] mreq_elem_o;
    logic             mack_i;
    logic             idle_o;
    logic             done_o;
    logic             err_o;

    thor2021_vmem_seq #(.MAXVL(MAXVL), .STEPW(STEPW), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .vec_i(vec_i), .store_i(store_i),
        .vl_i(vl_i), .mask_i(mask_i), .step_o(step_o), .mreq_o(mreq_o),
        .mreq_rdy_i(mreq_rdy_i), .mreq_we_o(mreq_we_o), .mreq_elem_o(mreq_elem_o),
        .mack_i(mack_i), .idle_o(idle_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   fails  = 0;

    // Model: list of element indices the op must request, in order.
    int   exp_q[$];
    int   idx;
    int   out_m;
    logic store_m;
    logic done_seen;
    int   last_elem;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle, entered and left at a negedge: check visible outputs, drive inputs, advance model.
    task automatic tick(input logic rdy, input logic ack);
        logic hs;
        if (mreq_o) begin
            checkOutput("req_in_range", 64'(idx < exp_q.size()), 64'd1);
            if (idx < exp_q.size()) checkOutput("req_elem", 64'(mreq_elem_o), 64'(exp_q[idx]));
            checkOutput("req_we", 64'(mreq_we_o), 64'(store_m));
            checkOutput("req_out_limit", 64'(out_m < MAXOUT), 64'd1);
        end
        if (done_o) begin
            checkOutput("done_all_issued", 64'(idx), 64'(exp_q.size()));
            checkOutput("done_all_acked", 64'(out_m), 64'd0);
            done_seen = 1'b1;
        end
        mreq_rdy_i = rdy;
        mack_i     = ack;
        hs = mreq_o && rdy;
        if (hs) begin
            last_elem = int'(mreq_elem_o);
            idx++;
        end
        if (hs && !ack) out_m++;
        else if (!hs && ack && out_m > 0) out_m--;
        @(negedge clk);
    endtask

    task automatic start_op(input logic vec, input logic st, input logic [STEPW:0] vl,
                            input logic [MAXVL-1:0] mask);
        int n;
        exp_q.delete();
        idx       = 0;
        done_seen = 1'b0;
        store_m   = st;
        n = vec ? ((int'(vl) > MAXVL) ? MAXVL : int'(vl)) : 1;
        for (int i = 0; i < n; i++) begin
            if (vec ? mask[i] : (i == 0)) exp_q.push_back(i);
        end
        checkOutput("idle_before_start", 64'(idle_o), 64'd1);
        vec_i   = vec;
        store_i = st;
        vl_i    = vl;
        mask_i  = mask;
        start_i = 1'b1;
        tick(1'b0, 1'b0);
        start_i = 1'b0;
    endtask

    task automatic applyStimulus(input int budget, input int rdy_pct, input int ack_pct,
                                 output int cycles);
        logic r, a;
        cycles = 0;
        while (!done_seen && cycles < budget) begin
            cycles++;
            r = ($urandom_range(1, 100) <= rdy_pct);
            a = (out_m > 0) && ($urandom_range(1, 100) <= ack_pct);
            tick(r, a);
        end
        checkOutput("op_completes", 64'(done_seen), 64'd1);
        checkOutput("idle_after_done", 64'(idle_o), 64'd1);
        checkOutput("done_one_pulse", 64'(done_o), 64'd0);
        checkOutput("err_clean_op", 64'(err_o), 64'd0);
    endtask

    initial begin
        int cyc;
        int n;
        logic [STEPW-1:0] held;
        logic [MAXVL-1:0] m;

        rst = 1'b1; start_i = 1'b0; vec_i = 1'b0; store_i = 1'b0; vl_i = '0;
        mask_i = '0; mreq_rdy_i = 1'b0; mack_i = 1'b0;
        idx = 0; out_m = 0; store_m = 1'b0; done_seen = 1'b0; last_elem = -1;
        repeat (2) @(negedge clk);
        checkOutput("rst_idle", 64'(idle_o), 64'd1);
        checkOutput("rst_mreq", 64'(mreq_o), 64'd0);
        checkOutput("rst_done", 64'(done_o), 64'd0);
        checkOutput("rst_err", 64'(err_o), 64'd0);
        checkOutput("rst_step", 64'(step_o), 64'd0);
        checkOutput("rst_elem", 64'(mreq_elem_o), 64'd0);
        checkOutput("rst_we", 64'(mreq_we_o), 64'd0);
        rst = 1'b0;
        tick(1'b0, 1'b0);

        // Scalar load, mask/vl inputs must be ignored.
        start_op(1'b0, 1'b0, 7'd9, 64'hFFFF_0000_0000_0000);
        applyStimulus(200, 100, 100, cyc);
        checkOutput("scalar_count", 64'(idx), 64'd1);

        // Vector store, vl=8, mask A5 -> elements 0,2,5,7.
        start_op(1'b1, 1'b1, 7'd8, 64'hA5);
        applyStimulus(300, 100, 100, cyc);
        checkOutput("a5_count", 64'(idx), 64'd4);
        checkOutput("a5_last", 64'(last_elem), 64'd7);

        // Acks withheld: exactly MAXOUT requests, then stall.
        start_op(1'b1, 1'b0, 7'd8, 64'hFF);
        repeat (40) tick(1'b1, 1'b0);
        checkOutput("limit_issued", 64'(idx), 64'(MAXOUT));
        checkOutput("limit_no_req", 64'(mreq_o), 64'd0);
        checkOutput("limit_busy", 64'(idle_o), 64'd0);
        tick(1'b1, 1'b1);
        repeat (10) tick(1'b1, 1'b0);
        checkOutput("limit_fifth", 64'(idx), 64'(MAXOUT + 1));
        applyStimulus(500, 100, 70, cyc);

        // Simultaneous handshake and ack at count 2, then backpressure on a held request.
        start_op(1'b1, 1'b1, 7'd8, 64'hFF);
        n = 0;
        while (!(out_m == 2 && mreq_o) && n < 60) begin
            tick(1'b1, 1'b0);
            n++;
        end
        checkOutput("reach_out2", 64'(out_m == 2 && mreq_o), 64'd1);
        tick(1'b1, 1'b1);
        repeat (30) tick(1'b1, 1'b0);
        checkOutput("simul_out4", 64'(out_m), 64'(MAXOUT));
        checkOutput("simul_issued", 64'(idx), 64'd5);
        tick(1'b0, 1'b1);
        n = 0;
        while (!mreq_o && n < 10) begin
            tick(1'b0, 1'b0);
            n++;
        end
        checkOutput("bp_req_up", 64'(mreq_o), 64'd1);
        held = mreq_elem_o;
        checkOutput("bp_elem", 64'(held), 64'd5);
        repeat (5) begin
            tick(1'b0, 1'b0);
            checkOutput("bp_hold_req", 64'(mreq_o), 64'd1);
            checkOutput("bp_hold_elem", 64'(mreq_elem_o), 64'(held));
            checkOutput("bp_hold_step", 64'(step_o), 64'(held));
        end
        applyStimulus(500, 100, 60, cyc);

        // Empty ops: done exactly three cycles after start.
        start_op(1'b1, 1'b0, 7'd0, 64'hFF);
        applyStimulus(20, 100, 100, cyc);
        checkOutput("vl0_latency", 64'(cyc), 64'd3);
        start_op(1'b1, 1'b1, 7'd20, 64'hFFFF_FFFF_FFF0_0000);
        applyStimulus(20, 100, 100, cyc);
        checkOutput("mask0_latency", 64'(cyc), 64'd3);

        // vl above MAXVL clamps.
        start_op(1'b1, 1'b0, 7'd70, '1);
        applyStimulus(3000, 100, 80, cyc);
        checkOutput("clamp_count", 64'(idx), 64'd64);
        checkOutput("clamp_last", 64'(last_elem), 64'd63);

        // Asynchronous reset mid-vector.
        start_op(1'b1, 1'b1, 7'd8, 64'hFF);
        n = 0;
        while (idx < 3 && n < 60) begin
            tick(1'b1, 1'b0);
            n++;
        end
        #1 rst = 1'b1;
        #1;
        checkOutput("arst_idle", 64'(idle_o), 64'd1);
        checkOutput("arst_mreq", 64'(mreq_o), 64'd0);
        checkOutput("arst_step", 64'(step_o), 64'd0);
        checkOutput("arst_elem", 64'(mreq_elem_o), 64'd0);
        checkOutput("arst_we", 64'(mreq_we_o), 64'd0);
        checkOutput("arst_done", 64'(done_o), 64'd0);
        mreq_rdy_i = 1'b0; mack_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); idx = 0; out_m = 0; done_seen = 1'b0;
        tick(1'b0, 1'b0);
        start_op(1'b1, 1'b0, 7'd8, 64'h3C);
        applyStimulus(300, 80, 60, cyc);
        checkOutput("post_rst_count", 64'(idx), 64'd4);

        // Randomized ops against the element-list model.
        for (int k = 0; k < 12; k++) begin
            m = {$urandom, $urandom};
            if (k % 3 == 1) m = m & {$urandom, $urandom};
            start_op(1'($urandom_range(0, 3) != 0), 1'($urandom), 7'($urandom_range(0, 72)), m);
            applyStimulus(3000, $urandom_range(30, 100), $urandom_range(20, 100), cyc);
        end

        // Stray ack while idle.
        tick(1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0);
        checkOutput("err_stray_ack", 64'(err_o), 64'(ERRCHK));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("err_cleared", 64'(err_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
